// File: rtl/line_refill_unit.sv
// Cache-miss line fill: fetches a 16-byte line as four 32-bit beats and delivers it downstream.
// Optional CRITICAL_WORD_FIRST_EN: the fetch starts at the requested word instead of word 0.
module line_refill_unit #(
    parameter int ADDR_W = 12,
    parameter int BEAT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [7:0]          mem_req_line,
    output logic [1:0]          mem_req_word,
    input  logic                mem_rsp_valid,
    input  logic [BEAT_W-1:0]   mem_rsp_data,
    output logic                early_valid,
    output logic [BEAT_W-1:0]   early_word,
    output logic                line_valid,
    input  logic                line_ready,
    output logic [4*BEAT_W-1:0] line_data,
    output logic [4:0]          line_tag,
    output logic [2:0]          line_set,
    output logic [3:0]          line_offset
);

    typedef enum logic [1:0] {IDLE, ISSUE, FILL, DELIVER} state_t;

    state_t                  state;
    logic [3:0][BEAT_W-1:0]  words;
    logic [1:0]              ptr;
    logic [1:0]              beat_cnt;
    logic [1:0]              start_word;

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_word = req_addr[3:2];
`else
    assign start_word = 2'd0;
`endif

    assign line_data    = words;
    assign mem_req_line = {line_tag, line_set};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            mem_req_valid <= 1'b0;
            line_valid    <= 1'b0;
            mem_req_word  <= 2'd0;
            early_valid   <= 1'b0;
            early_word    <= '0;
            words         <= '0;
            ptr           <= 2'd0;
            beat_cnt      <= 2'd0;
            line_tag      <= '0;
            line_set      <= '0;
            line_offset   <= '0;
        end else begin
            early_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        line_tag      <= req_addr[11:7];
                        line_set      <= req_addr[6:4];
                        line_offset   <= req_addr[3:0];
                        mem_req_word  <= start_word;
                        ptr           <= start_word;
                        beat_cnt      <= 2'd0;
                        req_ready     <= 1'b0;
                        mem_req_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= FILL;
                    end
                end
                FILL: begin
                    if (mem_rsp_valid) begin
                        words[ptr] <= mem_rsp_data;
                        ptr        <= ptr + 2'd1;
                        beat_cnt   <= beat_cnt + 2'd1;
                        // The requested word is identified by its slot, so both fill orders share this test.
                        if (ptr == line_offset[3:2]) begin
                            early_valid <= 1'b1;
                            early_word  <= mem_rsp_data;
                        end
                        if (beat_cnt == 2'd3) begin
                            line_valid <= 1'b1;
                            state      <= DELIVER;
                        end
                    end
                end
                DELIVER: begin
                    if (line_ready) begin
                        line_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
